// File: rtl/note_color_mixer_if.sv
// Note-event and mixed-colour bundle between the note sequencer (master)
// and the polyphonic colour mixer (slave).
interface note_color_mixer_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   note_on;
    logic [NUM_CH-1:0]   note_off;
    logic [6*NUM_CH-1:0] note_in;
    logic                tick;
    logic [7:0]          r;
    logic [7:0]          g;
    logic [7:0]          b;
    logic [NUM_CH-1:0]   active;

    modport master (
        output note_on, note_off, note_in, tick,
        input  r, g, b, active
    );

    modport slave (
        input  note_on, note_off, note_in, tick,
        output r, g, b, active
    );
endinterface

// File: rtl/note_color_mixer.sv
// Polyphonic note-to-colour engine: per-channel hold/decay envelopes feeding a
// two-stage registered scale-and-saturating-mix pipeline for the VGA path.
module note_color_mixer #(
    parameter int         NUM_CH     = 4,
    parameter int         FADE_SHIFT = 3,
    parameter int         OCT_STEP   = 12,
    parameter logic [7:0] SUSTAIN    = 8'd255
) (
    input  logic              clk,
    input  logic              reset,
    note_color_mixer_if.slave bus
);
    localparam int SUM_W = 8 + $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DECAY
    } ch_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    ch_state_e  state_q  [NUM_CH];
    ch_state_e  state_d  [NUM_CH];
    logic [7:0] level_q  [NUM_CH];
    logic [7:0] level_d  [NUM_CH];
    logic [5:0] note_q   [NUM_CH];
    logic [5:0] note_d   [NUM_CH];
    rgb_t       base_c   [NUM_CH];
    rgb_t       scaled_q [NUM_CH];
    rgb_t       scaled_d [NUM_CH];
    rgb_t       mix_q;
    rgb_t       mix_d;
    logic [7:0] step;
    logic [SUM_W-1:0] sum_r;
    logic [SUM_W-1:0] sum_g;
    logic [SUM_W-1:0] sum_b;

    function automatic rgb_t palette(input logic [5:0] h);
        rgb_t p;
        case (h)
            6'd0:    p = {8'd114, 8'd244, 8'd0};
            6'd1:    p = {8'd242, 8'd244, 8'd0};
            6'd2:    p = {8'd243, 8'd117, 8'd0};
            6'd3:    p = {8'd232, 8'd0,   8'd0};
            6'd4:    p = {8'd255, 8'd0,   8'd122};
            6'd5:    p = {8'd255, 8'd0,   8'd250};
            6'd6:    p = {8'd133, 8'd0,   8'd255};
            6'd7:    p = {8'd5,   8'd0,   8'd255};
            6'd8:    p = {8'd0,   8'd123, 8'd255};
            6'd9:    p = {8'd0,   8'd251, 8'd255};
            6'd10:   p = {8'd0,   8'd253, 8'd130};
            6'd11:   p = {8'd0,   8'd253, 8'd2};
            default: p = '0;
        endcase
        return p;
    endfunction

    // A zero component can never exceed dim, so it stays zero here as well.
    function automatic logic [7:0] dim_comp(input logic [7:0] c, input int unsigned dim);
        int unsigned cw;
        cw = 32'(c);
        return (cw > dim) ? 8'(cw - dim) : 8'd0;
    endfunction

    function automatic rgb_t base_colour(input logic [5:0] n);
        logic [2:0]  oct;
        logic [5:0]  hue;
        int unsigned dim;
        rgb_t        p;
        if      (n >= 6'd60) oct = 3'd5;
        else if (n >= 6'd48) oct = 3'd4;
        else if (n >= 6'd36) oct = 3'd3;
        else if (n >= 6'd24) oct = 3'd2;
        else if (n >= 6'd12) oct = 3'd1;
        else                 oct = 3'd0;
        hue = n - (6'd12 * {3'd0, oct});
        dim = int'(unsigned'(OCT_STEP)) * (32'd5 - 32'(oct));
        p   = palette(hue);
        return {dim_comp(p.r, dim), dim_comp(p.g, dim), dim_comp(p.b, dim)};
    endfunction

    // level+1 turns the 0..255 envelope into a 1..256 multiplier, so full level is exact.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, lvl} + 16'd1);
        return (lvl == 8'd0) ? 8'd0 : 8'(prod >> 8);
    endfunction

    // NOTE: always_comb uses blocking '=' with every output defaulted first, so no
    // latch can be inferred; the always_ff blocks below use only non-blocking '<='.
    always_comb begin
        step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            note_d[i]  = note_q[i];
            if (bus.note_on[i]) begin
                state_d[i] = ST_HOLD;
                level_d[i] = SUSTAIN;
                note_d[i]  = bus.note_in[6*i +: 6];
            end else begin
                case (state_q[i])
                    ST_HOLD: begin
                        if (bus.note_off[i]) state_d[i] = ST_DECAY;
                    end
                    ST_DECAY: begin
                        if (bus.tick) begin
                            step = level_q[i] >> FADE_SHIFT;
                            if (step == 8'd0) step = 8'd1;
                            if (step >= level_q[i]) begin
                                level_d[i] = 8'd0;
                                state_d[i] = ST_IDLE;
                            end else begin
                                level_d[i] = level_q[i] - step;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: these per-channel arrays are small flop banks, not RAM, so they are
    // reset explicitly to give a defined colour straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                level_q[i] <= '0;
                note_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
                note_q[i]  <= note_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            base_c[i]   = base_colour(note_q[i]);
            scaled_d[i] = {scale(base_c[i].r, level_q[i]),
                           scale(base_c[i].g, level_q[i]),
                           scale(base_c[i].b, level_q[i])};
        end
    end

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_r = sum_r + SUM_W'(scaled_q[i].r);
            sum_g = sum_g + SUM_W'(scaled_q[i].g);
            sum_b = sum_b + SUM_W'(scaled_q[i].b);
        end
        mix_d.r = (sum_r > SUM_W'(255)) ? 8'hFF : sum_r[7:0];
        mix_d.g = (sum_g > SUM_W'(255)) ? 8'hFF : sum_g[7:0];
        mix_d.b = (sum_b > SUM_W'(255)) ? 8'hFF : sum_b[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) scaled_q[i] <= '0;
            mix_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) scaled_q[i] <= scaled_d[i];
            mix_q <= mix_d;
        end
    end

    always_comb begin
        bus.active = '0;
        for (int i = 0; i < NUM_CH; i++) bus.active[i] = (state_q[i] != ST_IDLE);
    end

    assign bus.r = mix_q.r;
    assign bus.g = mix_q.g;
    assign bus.b = mix_q.b;
endmodule

// File: tb/tb_note_color_mixer.sv
// Randomized and directed bench for note_color_mixer against an arithmetic
// reference model of the envelopes and the two-cycle colour pipeline.
module tb_note_color_mixer;
    localparam int NUM_CH     = 4;
    localparam int FADE_SHIFT = 3;
    localparam int OCT_STEP   = 12;
    localparam int SUSTAIN    = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_color_mixer_if #(.NUM_CH(NUM_CH)) bus ();

    note_color_mixer #(
        .NUM_CH    (NUM_CH),
        .FADE_SHIFT(FADE_SHIFT),
        .OCT_STEP  (OCT_STEP),
        .SUSTAIN   (8'(SUSTAIN))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int PAL [12][3] = '{
        '{114, 244, 0}, '{242, 244, 0}, '{243, 117, 0}, '{232, 0, 0},
        '{255, 0, 122}, '{255, 0, 250}, '{133, 0, 255}, '{5, 0, 255},
        '{0, 123, 255}, '{0, 251, 255}, '{0, 253, 130}, '{0, 253, 2}
    };

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Reference model: envelope level, held flag and note per channel; a channel
    // is sounding while its level is nonzero.
    int m_level [NUM_CH];
    int m_note  [NUM_CH];
    bit m_held  [NUM_CH];
    int exp_mid [3];
    int exp_out [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mix_comp(int c);
        int sum = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m_level[ch] > 0) begin
                int oct  = m_note[ch] / 12;
                int base = PAL[m_note[ch] % 12][c];
                if (base != 0) begin
                    base = base - OCT_STEP * (5 - oct);
                    if (base < 0) base = 0;
                end
                sum += base * (m_level[ch] + 1) / 256;
            end
        end
        return (sum > 255) ? 255 : sum;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_level[ch] = 0;
            m_note[ch]  = 0;
            m_held[ch]  = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            exp_mid[c] = 0;
            exp_out[c] = 0;
        end
    endtask

    task automatic model_update();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.note_on[ch]) begin
                m_level[ch] = SUSTAIN;
                m_held[ch]  = 1'b1;
                m_note[ch]  = int'(bus.note_in[6*ch +: 6]);
            end else if (m_held[ch]) begin
                if (bus.note_off[ch]) m_held[ch] = 1'b0;
            end else if (m_level[ch] > 0 && bus.tick) begin
                int dec = m_level[ch] / (1 << FADE_SHIFT);
                if (dec < 1) dec = 1;
                m_level[ch] = (dec > m_level[ch]) ? 0 : m_level[ch] - dec;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] exp_act;
        for (int ch = 0; ch < NUM_CH; ch++) exp_act[ch] = (m_level[ch] > 0);
        check($sformatf("%s.active", phase), 32'(bus.active), 32'(exp_act));
        check($sformatf("%s.r", phase), 32'(bus.r), exp_out[0]);
        check($sformatf("%s.g", phase), 32'(bus.g), exp_out[1]);
        check($sformatf("%s.b", phase), 32'(bus.b), exp_out[2]);
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare at the falling edge and clear the single-cycle strobes.
    task automatic cycle();
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            exp_out[c] = exp_mid[c];
            exp_mid[c] = mix_comp(c);
        end
        model_update();
        @(negedge clk);
        check_outputs();
        bus.note_on  = '0;
        bus.note_off = '0;
        bus.tick     = 1'b0;
    endtask

    task automatic fire_on(input int ch, input int note);
        bus.note_on[ch]         = 1'b1;
        bus.note_in[6*ch +: 6]  = 6'(note);
    endtask

    task automatic expect_rgb(input string tag, input int er, input int eg, input int eb);
        check({tag, ".r"}, 32'(bus.r), er);
        check({tag, ".g"}, 32'(bus.g), eg);
        check({tag, ".b"}, 32'(bus.b), eb);
    endtask

    initial begin
        int n;
        int exp_ticks;
        int lvl;

        reset        = 1'b1;
        bus.note_on  = '0;
        bus.note_off = '0;
        bus.note_in  = '0;
        bus.tick     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        expect_rgb("reset", 0, 0, 0);
        check("reset.active", 32'(bus.active), 0);
        reset = 1'b0;

        phase = "n60";
        fire_on(0, 60);
        cycle();
        check("n60.active0", 32'(bus.active[0]), 1);
        repeat (2) cycle();
        expect_rgb("n60", 114, 244, 0);
        check("n60.others", 32'(bus.active[NUM_CH-1:1]), 0);

        phase = "n0";
        fire_on(0, 0);
        repeat (3) cycle();
        expect_rgb("n0", 54, 184, 0);

        phase = "n63";
        fire_on(0, 63);
        repeat (3) cycle();
        expect_rgb("n63", 232, 0, 0);

        phase = "hold_tick";
        fire_on(0, 60);
        repeat (3) cycle();
        repeat (2) begin
            bus.tick = 1'b1;
            cycle();
        end
        repeat (2) cycle();
        expect_rgb("hold_tick", 114, 244, 0);
        bus.note_off[0] = 1'b1;
        cycle();
        bus.tick = 1'b1;
        cycle();
        repeat (2) cycle();
        expect_rgb("one_tick", 100, 214, 0);

        phase = "sat";
        fire_on(0, 63);
        fire_on(1, 51);
        repeat (3) cycle();
        expect_rgb("sat", 255, 0, 0);
        bus.note_off[1] = 1'b1;
        cycle();
        n = 0;
        while (bus.active[1] && n < 100) begin
            bus.tick = 1'b1;
            cycle();
            n++;
        end
        check("ch1_idle", 32'(bus.active[1]), 0);
        repeat (2) cycle();
        expect_rgb("ch1_gone", 232, 0, 0);

        phase = "decay0";
        exp_ticks = 0;
        lvl       = SUSTAIN;
        while (lvl > 0) begin
            lvl = lvl - (((lvl >> FADE_SHIFT) > 0) ? (lvl >> FADE_SHIFT) : 1);
            exp_ticks++;
        end
        bus.note_off[0] = 1'b1;
        cycle();
        n = 0;
        while (bus.active[0] && n < 100) begin
            bus.tick = 1'b1;
            cycle();
            n++;
        end
        check("decay_ticks", 32'(n), 32'(exp_ticks));
        check("decay_idle", 32'(bus.active[0]), 0);
        repeat (2) cycle();
        expect_rgb("decay_black", 0, 0, 0);

        phase = "on_off";
        fire_on(0, 10);
        bus.note_off[0] = 1'b1;
        cycle();
        bus.tick = 1'b1;
        repeat (3) cycle();
        check("on_off.active0", 32'(bus.active[0]), 1);
        expect_rgb("on_off", 0, 193, 70);

        phase = "retrigger";
        bus.note_off[0] = 1'b1;
        cycle();
        repeat (3) begin
            bus.tick = 1'b1;
            cycle();
        end
        fire_on(0, 10);
        repeat (3) cycle();
        expect_rgb("retrigger", 0, 193, 70);

        phase = "async_rst";
        fire_on(2, 33);
        repeat (3) cycle();
        bus.note_off[2] = 1'b1;
        cycle();
        bus.tick = 1'b1;
        cycle();
        #2 reset = 1'b1;
        #1;
        expect_rgb("async_rst", 0, 0, 0);
        check("async_rst.active", 32'(bus.active), 0);
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
        phase = "tick_only";
        bus.tick = 1'b1;
        repeat (3) cycle();
        expect_rgb("tick_only", 0, 0, 0);

        phase = "random";
        for (int k = 0; k < 800; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 15) == 0) fire_on(ch, int'($urandom_range(0, 63)));
                if ($urandom_range(0, 7) == 0) bus.note_off[ch] = 1'b1;
            end
            bus.tick = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/note_color_mixer.md
Name: note_color_mixer

Overview:
- Polyphonic note-to-colour engine for the VGA display path.
- Tracks NUM_CH independent note channels. Each channel has a note-derived base colour and an 8-bit intensity envelope (hold, then decay on frame ticks).
- Emits one registered, saturating RGB mix of all active channels.
- Sits between the composition/note sequencer and the VGA pixel generator, and replaces the single-note combinational colour lookup.

Parameters:
- NUM_CH, 4, number of independent note channels (1..8).
- FADE_SHIFT, 3, decay step per tick = max(level >> FADE_SHIFT, 1).
- OCT_STEP, 12, per-octave dimming subtracted from each nonzero base component.
- SUSTAIN, 255, level loaded on note_on and held until note_off.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- note_on  input  NUM_CH  per-channel single-cycle strobe that starts a note.
- note_off  input  NUM_CH  per-channel single-cycle strobe that releases a note.
- note_in  input  6*NUM_CH  note index per channel (channel i at bits [6i+5:6i]), sampled on note_on.
- tick  input  1  frame-rate pulse (one cycle) that advances decay.
- r  output  8  mixed red.
- g  output  8  mixed green.
- b  output  8  mixed blue.
- active  output  NUM_CH  1 while the channel state is not IDLE.

Behaviour:
- Reset: asynchronous. All channels go to IDLE with level=0 and latched note=0. The pipeline registers, r/g/b and active are all 0.
- Base colour of note n: hue h = n mod 12, octave o = n / 12 (0..5).
- Palette P[h] (r,g,b):
  - 0:(114,244,0)
  - 1:(242,244,0)
  - 2:(243,117,0)
  - 3:(232,0,0)
  - 4:(255,0,122)
  - 5:(255,0,250)
  - 6:(133,0,255)
  - 7:(5,0,255)
  - 8:(0,123,255)
  - 9:(0,251,255)
  - 10:(0,253,130)
  - 11:(0,253,2)
- Each component equal to 0 stays 0. Every other component becomes max(comp - OCT_STEP*(5-o), 0).
- Per-channel FSM, updated on each clk edge:
  - note_on (any state) -> HOLD. Latch note_in. level = SUSTAIN. This restarts the envelope.
  - HOLD & note_off -> DECAY. level unchanged.
  - DECAY & tick -> level -= max(level >> FADE_SHIFT, 1). At 0 -> IDLE.
  - note_off in IDLE or DECAY: ignored.
  - tick in HOLD or IDLE: ignored.
  - note_on and note_off in the same cycle on one channel: note_on wins (HOLD, level=SUSTAIN).
- Level never underflows.
- active[i] = (state_i != IDLE). It is registered with the state.
- Stage 1 (registered): per channel and component, scaled = (level==0) ? 0 : (comp*(level+1)) >> 8. At level 255 this gives comp exactly.
- Stage 2 (registered): r/g/b = min(sum of scaled over channels, 255). The adder width is 8+ceil(log2 NUM_CH).
- Latency:
  - An input event at edge k updates state/level at k+1.
  - The new colour appears on r/g/b after edge k+3, i.e. 2 cycles after level.
- Outputs are stable between state changes.
- Channels are fully independent. Events on different channels in the same cycle are all applied.

Test Plan:
- Reset, then note_on[0] with note_in=60 -> active[0]=1 one cycle later; (r,g,b)=(114,244,0) three cycles after the strobe. All other channels stay 0.
- note_on[0] with note 0 -> octave 0, dimming 60 -> (54,184,0). Note 63 -> (232,0,0).
- Note 60 held, then note_off[0], then one tick -> level 255→224; (r,g,b)=(100,214,0). Ticks before note_off leave level at 255.
- note_on[0] note 63 and note_on[1] note 51 (220,0,0) in the same cycle -> r saturates at 255, g=b=0. Then release ch1 and decay it to IDLE -> r returns to 232 and active[1]=0.
- Decay to zero: FADE_SHIFT=3, count ticks from 255. The last steps are 1 each. Required: level reaches 0 with no underflow, the state goes to IDLE, and RGB returns to 0 two cycles later.
- Corner events:
  - note_on and note_off together -> HOLD.
  - note_on during DECAY -> level back to 255.
  - reset asserted mid-decay, asynchronous to clk -> all outputs 0 immediately.
  - After reset deasserts, a tick alone produces no output.
